// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDiscard
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response handshake between fetch and memory.
interface fetch_pc_unit_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: exception target > pending/live branch redirect > pc+4.
module next_pc_sel (
  input  logic        flush_exc,
  input  logic [31:0] exc_pc,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (flush_exc) begin
      next_pc = exc_pc;
    end else if (redir_pend) begin
      next_pc = redir_tgt;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// MIPS fetch stage: owns the PC, runs the single-outstanding imem handshake and
// applies branch redirects after the delay slot and exception redirects at once.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallF,
  input  logic                   flush_exc,
  input  logic [31:0]            exc_pc,
  input  logic                   branch_takenD,
  input  logic [31:0]            branch_targetD,
  input  logic                   is_branchD,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            pcF,
  output logic [31:0]            pcplus4F,
  output logic [31:0]            instrF,
  output logic                   is_in_delayslot_iF,
  output logic                   instr_validF,
  output logic                   adelF,
  output logic                   fetch_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_tgt_q, redir_tgt_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         req;
  logic         req_acc;
  logic         fire;

  assign pc_plus4   = pc_q + 32'd4;
  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    req          = 1'b0;
    instr_validF = 1'b0;
    instrF       = NOP;
    adelF        = 1'b0;
    unique case (state_q)
      StReq: begin
        // A misaligned PC is reported as a valid faulting instruction, never fetched.
        if (misaligned) begin
          instr_validF = 1'b1;
          adelF        = 1'b1;
        end else begin
          req = 1'b1;
        end
      end
      StWait: begin
        if (imem.inst_data_ok) begin
          instr_validF = 1'b1;
          instrF       = imem.inst_rdata;
        end
      end
      StHold: begin
        instr_validF = 1'b1;
        instrF       = ibuf_q;
      end
      StDiscard: begin
      end
    endcase
    if (rst) begin
      req          = 1'b0;
      instr_validF = 1'b0;
      instrF       = NOP;
      adelF        = 1'b0;
    end
  end

  assign imem.inst_req      = req;
  assign imem.inst_addr     = rst ? 32'h0 : pc_q;
  assign pcF                = pc_q;
  assign pcplus4F           = pc_plus4;
  assign is_in_delayslot_iF = is_branchD & instr_validF;
  assign fetch_stall        = ~instr_validF & ~rst;
  assign req_acc            = req & imem.inst_addr_ok;
  assign fire               = instr_validF & ~stallF & ~flush_exc;

  next_pc_sel u_next_pc_sel (
    .flush_exc     (flush_exc),
    .exc_pc        (exc_pc),
    .redir_pend    (redir_pend_q),
    .redir_tgt     (redir_tgt_q),
    .branch_taken  (branch_takenD),
    .branch_target (branch_targetD),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    ibuf_d       = ibuf_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    pc_d         = (fire | flush_exc) ? next_pc : pc_q;

    // Remember a taken branch until its delay slot leaves F.
    if (branch_takenD) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = branch_targetD;
    end
    if (fire | flush_exc) begin
      redir_pend_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (flush_exc) begin
          state_d = req_acc ? StDiscard : StReq;
        end else if (req_acc) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem.inst_data_ok) begin
          if (flush_exc || !stallF) begin
            state_d = StReq;
          end else begin
            state_d = StHold;
            ibuf_d  = imem.inst_rdata;
          end
        end else if (flush_exc) begin
          state_d = StDiscard;
        end
      end
      StHold: begin
        if (flush_exc || fire) begin
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (imem.inst_data_ok) begin
          state_d = StReq;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      ibuf_q       <= NOP;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_q       <= ibuf_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed cycle-by-cycle bench for fetch_pc_unit; inputs change on negedge, checks 1ns later.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        flush_exc;
  logic [31:0] exc_pc;
  logic        branch_takenD;
  logic [31:0] branch_targetD;
  logic        is_branchD;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;
  logic [31:0] instrF;
  logic        is_in_delayslot_iF;
  logic        instr_validF;
  logic        adelF;
  logic        fetch_stall;

  int passed;
  int total;

  fetch_pc_unit_if imem ();

  fetch_pc_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .stallF             (stallF),
    .flush_exc          (flush_exc),
    .exc_pc             (exc_pc),
    .branch_takenD      (branch_takenD),
    .branch_targetD     (branch_targetD),
    .is_branchD         (is_branchD),
    .imem               (imem.master),
    .pcF                (pcF),
    .pcplus4F           (pcplus4F),
    .instrF             (instrF),
    .is_in_delayslot_iF (is_in_delayslot_iF),
    .instr_validF       (instr_validF),
    .adelF              (adelF),
    .fetch_stall        (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    #1;
    total++; if (pcF !== 32'hBFC0_0000) $display("FAIL rst_pcF: got %h want bfc00000", pcF); else passed++;
    total++; if (pcplus4F !== 32'hBFC0_0004) $display("FAIL rst_pcplus4F: got %h want bfc00004", pcplus4F); else passed++;
    total++; if (imem.inst_req !== 1'b0) $display("FAIL rst_inst_req: got %b want 0", imem.inst_req); else passed++;
    total++; if (imem.inst_addr !== 32'h0) $display("FAIL rst_inst_addr: got %h want 0", imem.inst_addr); else passed++;
    total++; if (fetch_stall !== 1'b0) $display("FAIL rst_fetch_stall: got %b want 0", fetch_stall); else passed++;
    total++; if (instr_validF !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    imem.inst_addr_ok = 1'b1; imem.inst_data_ok = 1'b0; #1;
    total++; if (imem.inst_req !== 1'b1) $display("FAIL seq_req0: got %b want 1", imem.inst_req); else passed++;
    total++; if (imem.inst_addr !== 32'hBFC0_0000) $display("FAIL seq_addr0: got %h want bfc00000", imem.inst_addr); else passed++;
    total++; if (fetch_stall !== 1'b1) $display("FAIL seq_stall0: got %b want 1", fetch_stall); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h1111_1111; #1;
    total++; if (instr_validF !== 1'b1) $display("FAIL seq_valid1: got %b want 1", instr_validF); else passed++;
    total++; if (instrF !== 32'h1111_1111) $display("FAIL seq_instr1: got %h want 11111111", instrF); else passed++;
    total++; if (fetch_stall !== 1'b0) $display("FAIL seq_stall1: got %b want 0", fetch_stall); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; #1;
    total++; if (imem.inst_addr !== 32'hBFC0_0004) $display("FAIL seq_addr2: got %h want bfc00004", imem.inst_addr); else passed++;
    total++; if (instr_validF !== 1'b0) $display("FAIL seq_valid2: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h2222_2222; #1;
    total++; if (instr_validF !== 1'b1) $display("FAIL seq_valid3: got %b want 1", instr_validF); else passed++;
    total++; if (pcF !== 32'hBFC0_0004) $display("FAIL seq_pc3: got %h want bfc00004", pcF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; #1;
    total++; if (imem.inst_addr !== 32'hBFC0_0008) $display("FAIL seq_addr4: got %h want bfc00008", imem.inst_addr); else passed++;
    @(negedge clk);
  endtask

  task automatic test_stall_hold();
    imem.inst_addr_ok = 1'b0; imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h3333_3333;
    stallF = 1'b1; #1;
    total++; if (instrF !== 32'h3333_3333) $display("FAIL hold_bypass: got %h want 33333333", instrF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; imem.inst_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (instrF !== 32'h3333_3333) $display("FAIL hold_instr%0d: got %h want 33333333", i, instrF); else passed++;
      total++; if (instr_validF !== 1'b1) $display("FAIL hold_valid%0d: got %b want 1", i, instr_validF); else passed++;
      @(negedge clk);
    end
    stallF = 1'b0; #1;
    total++; if (pcF !== 32'hBFC0_0008) $display("FAIL hold_pc: got %h want bfc00008", pcF); else passed++;
    @(negedge clk);
    #1;
    total++; if (imem.inst_addr !== 32'hBFC0_000C) $display("FAIL hold_single_fire: got %h want bfc0000c", imem.inst_addr); else passed++;
    total++; if (instr_validF !== 1'b0) $display("FAIL hold_after_valid: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
  endtask

  task automatic test_branch_delay_slot();
    flush_exc = 1'b1; exc_pc = 32'h0000_0104;
    @(negedge clk);
    flush_exc = 1'b0; imem.inst_addr_ok = 1'b1; #1;
    total++; if (imem.inst_addr !== 32'h0000_0104) $display("FAIL br_addr: got %h want 00000104", imem.inst_addr); else passed++;
    @(negedge clk);
    imem.inst_addr_ok = 1'b0; branch_takenD = 1'b1; branch_targetD = 32'h0000_0200; is_branchD = 1'b1; #1;
    total++; if (is_in_delayslot_iF !== 1'b0) $display("FAIL br_ds_early: got %b want 0", is_in_delayslot_iF); else passed++;
    @(negedge clk);
    branch_takenD = 1'b0; branch_targetD = 32'hDEAD_BEEC;
    imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h2400_0001; #1;
    total++; if (is_in_delayslot_iF !== 1'b1) $display("FAIL br_ds: got %b want 1", is_in_delayslot_iF); else passed++;
    total++; if (pcF !== 32'h0000_0104) $display("FAIL br_ds_pc: got %h want 00000104", pcF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; is_branchD = 1'b0; #1;
    total++; if (imem.inst_addr !== 32'h0000_0200) $display("FAIL br_target: got %h want 00000200", imem.inst_addr); else passed++;
    @(negedge clk);
  endtask

  task automatic test_flush_wait();
    imem.inst_addr_ok = 1'b1;
    @(negedge clk);
    imem.inst_addr_ok = 1'b0; flush_exc = 1'b1; exc_pc = 32'hBFC0_0380; #1;
    total++; if (instr_validF !== 1'b0) $display("FAIL fw_valid0: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
    flush_exc = 1'b0; #1;
    total++; if (imem.inst_req !== 1'b0) $display("FAIL fw_no_req: got %b want 0", imem.inst_req); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'hBAAD_F00D; #1;
    total++; if (instr_validF !== 1'b0) $display("FAIL fw_stale_data: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; #1;
    total++; if (imem.inst_req !== 1'b1) $display("FAIL fw_req: got %b want 1", imem.inst_req); else passed++;
    total++; if (imem.inst_addr !== 32'hBFC0_0380) $display("FAIL fw_addr: got %h want bfc00380", imem.inst_addr); else passed++;
    @(negedge clk);
  endtask

  task automatic test_flush_addr_ok();
    branch_takenD = 1'b1; branch_targetD = 32'h0000_0500;
    @(negedge clk);
    branch_takenD = 1'b0; flush_exc = 1'b1; exc_pc = 32'h0000_1000; imem.inst_addr_ok = 1'b1; #1;
    total++; if (imem.inst_req !== 1'b1) $display("FAIL fa_req: got %b want 1", imem.inst_req); else passed++;
    @(negedge clk);
    flush_exc = 1'b0; imem.inst_addr_ok = 1'b0; imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'hCAFE_F00D; #1;
    total++; if (instr_validF !== 1'b0) $display("FAIL fa_dropped: got %b want 0", instr_validF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; imem.inst_addr_ok = 1'b1; #1;
    total++; if (imem.inst_addr !== 32'h0000_1000) $display("FAIL fa_addr: got %h want 00001000", imem.inst_addr); else passed++;
    @(negedge clk);
    imem.inst_addr_ok = 1'b0; imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h0000_AAAA; #1;
    total++; if (instr_validF !== 1'b1) $display("FAIL fa_valid: got %b want 1", instr_validF); else passed++;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; #1;
    total++; if (imem.inst_addr !== 32'h0000_1004) $display("FAIL fa_pend_cleared: got %h want 00001004", imem.inst_addr); else passed++;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    imem.inst_addr_ok = 1'b1;
    @(negedge clk);
    imem.inst_addr_ok = 1'b0; imem.inst_data_ok = 1'b1; imem.inst_rdata = 32'h1234_5678;
    branch_takenD = 1'b1; branch_targetD = 32'h0000_0202; is_branchD = 1'b1;
    @(negedge clk);
    imem.inst_data_ok = 1'b0; branch_takenD = 1'b0; is_branchD = 1'b0; stallF = 1'b1; #1;
    total++; if (adelF !== 1'b1) $display("FAIL mis_adel: got %b want 1", adelF); else passed++;
    total++; if (instrF !== 32'h0) $display("FAIL mis_instr: got %h want 0", instrF); else passed++;
    total++; if (instr_validF !== 1'b1) $display("FAIL mis_valid: got %b want 1", instr_validF); else passed++;
    total++; if (imem.inst_req !== 1'b0) $display("FAIL mis_req: got %b want 0", imem.inst_req); else passed++;
    total++; if (pcF !== 32'h0000_0202) $display("FAIL mis_pc: got %h want 00000202", pcF); else passed++;
    @(negedge clk);
    stallF = 1'b0;
    @(negedge clk);
    stallF = 1'b1; #1;
    total++; if (pcF !== 32'h0000_0206) $display("FAIL mis_next_pc: got %h want 00000206", pcF); else passed++;
    total++; if (adelF !== 1'b1) $display("FAIL mis_adel2: got %b want 1", adelF); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    stallF = 1'b0; rst = 1'b1; #1;
    total++; if (pcF !== 32'hBFC0_0000) $display("FAIL rst2_pcF: got %h want bfc00000", pcF); else passed++;
    total++; if (imem.inst_addr !== 32'h0) $display("FAIL rst2_addr: got %h want 0", imem.inst_addr); else passed++;
    total++; if (adelF !== 1'b0) $display("FAIL rst2_adel: got %b want 0", adelF); else passed++;
    total++; if (instr_validF !== 1'b0) $display("FAIL rst2_valid: got %b want 0", instr_validF); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    stallF = 1'b0;
    flush_exc = 1'b0;
    exc_pc = 32'h0;
    branch_takenD = 1'b0;
    branch_targetD = 32'h0;
    is_branchD = 1'b0;
    imem.inst_addr_ok = 1'b0;
    imem.inst_data_ok = 1'b0;
    imem.inst_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch_delay_slot();
    test_flush_wait();
    test_flush_addr_ok();
    test_misaligned();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
